// File: rtl/operand_slice_serializer.sv
// Parallel-in, slice-serial-out operand unloader (LSB slice first); SERIALIZER_BACK_TO_BACK_EN enables gapless reload.
// Latency: first slice presented the cycle after the load edge; NUM_SLICES beats per operand.
// Backpressure: out_ready low holds the current slice; in_ready is state-derived (plus out_ready when back-to-back).
module operand_slice_serializer #(
    parameter int WIDTH       = 16,
    parameter int SLICE_WIDTH = 2,
    parameter int NUM_SLICES  = WIDTH / SLICE_WIDTH,
    parameter int IDX_W       = (NUM_SLICES > 2) ? $clog2(NUM_SLICES) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [SLICE_WIDTH-1:0] out_data,
    output logic [IDX_W-1:0]       out_index,
    output logic                   out_last
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] shift_q;
    logic [IDX_W-1:0] idx_q;
    logic             at_last;
    logic             load;
    logic             beat;

    assign at_last = (idx_q == LAST_IDX);
    assign load    = in_valid && in_ready;
    assign beat    = out_valid && out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (load) begin
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // A load can only coincide with the final beat in back-to-back builds.
                if (beat && at_last) begin
                    state_d = load ? S_SHIFT : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        out_valid = (state_q == S_SHIFT);
        out_last  = out_valid && at_last;
`ifdef SERIALIZER_BACK_TO_BACK_EN
        in_ready  = (state_q == S_IDLE) || (out_last && out_ready);
`else
        in_ready  = (state_q == S_IDLE);
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_q <= '0;
            idx_q   <= '0;
        end else if (load) begin
            shift_q <= in_data;
            idx_q   <= '0;
        end else if (beat) begin
            // Index returns to 0 after the last slice so it never exceeds NUM_SLICES-1.
            shift_q <= shift_q >> SLICE_WIDTH;
            idx_q   <= at_last ? '0 : idx_q + 1'b1;
        end
    end

    assign out_data  = shift_q[SLICE_WIDTH-1:0];
    assign out_index = idx_q;

endmodule
